// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register endpoint: A/B read-write, registered SUM, write counter.
// Independent AW/W capture slots fire together; the read path has its own single-entry response register.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  logic [DATA_WIDTH-1:0] reg_a, reg_b, reg_sum, reg_wcount;
  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;

  logic                  aw_hs, w_hs, ar_hs, fire;
  logic                  aw_full_nx, w_full_nx, bvalid_nx, rvalid_nx;
  logic [RESP_WIDTH-1:0] wr_resp, rd_resp;
  logic [1:0]            wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_merged, rd_value;
  logic                  unused_wstrb_msb;

  assign unused_wstrb_msb = s_axi_wstrb[NB];

  function automatic logic [RESP_WIDTH-1:0] decode(input logic [ADDR_WIDTH-1:0] addr,
                                                   input logic is_write);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - ADDR_WIDTH'(BASE_ADDR);
    if (off > ADDR_WIDTH'(15) || addr[1:0] != 2'b00) return RESP_DECERR;
    if (is_write && off[3]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign fire   = aw_full & w_full;

  assign wr_resp = decode(aw_addr, 1'b1);
  assign rd_resp = decode(s_axi_araddr, 1'b0);
  assign wr_idx  = 2'((aw_addr - ADDR_WIDTH'(BASE_ADDR)) >> 2);
  assign rd_idx  = 2'((s_axi_araddr - ADDR_WIDTH'(BASE_ADDR)) >> 2);

  always_comb begin
    wr_merged = wr_idx[0] ? reg_b : reg_a;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_strb[i]) wr_merged[8*i +: 8] = w_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_value = '0;
    if (rd_resp == RESP_OKAY) begin
      case (rd_idx)
        2'd0:    rd_value = reg_a;
        2'd1:    rd_value = reg_b;
        2'd2:    rd_value = reg_sum;
        default: rd_value = reg_wcount;
      endcase
    end
  end

  // Ready flags are registered from next-state so they stay low in reset
  // and rise on the first edge after it, while still tracking slot/valid state.
  always_comb begin
    aw_full_nx = !fire && (aw_full || aw_hs);
    w_full_nx  = !fire && (w_full || w_hs);
    bvalid_nx  = fire || (s_axi_bvalid && !s_axi_bready);
    rvalid_nx  = ar_hs || (s_axi_rvalid && !s_axi_rready);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= '0;
      s_axi_rdata   <= '0;
      reg_a         <= '0;
      reg_b         <= '0;
      reg_sum       <= '0;
      reg_wcount    <= '0;
    end else begin
      aw_full       <= aw_full_nx;
      w_full        <= w_full_nx;
      s_axi_bvalid  <= bvalid_nx;
      s_axi_rvalid  <= rvalid_nx;
      s_axi_awready <= !aw_full_nx && !bvalid_nx;
      s_axi_wready  <= !w_full_nx && !bvalid_nx;
      s_axi_arready <= !rvalid_nx;
      reg_sum       <= reg_a + reg_b;
      if (aw_hs) aw_addr <= s_axi_awaddr;
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb[NB-1:0];
      end
      if (fire) begin
        s_axi_bresp <= wr_resp;
        if (wr_resp == RESP_OKAY) begin
          reg_wcount <= reg_wcount + DATA_WIDTH'(1);
          if (wr_idx == 2'd0) reg_a <= wr_merged;
          if (wr_idx == 2'd1) reg_b <= wr_merged;
        end
      end
      if (ar_hs) begin
        s_axi_rdata <= rd_value;
        s_axi_rresp <= rd_resp;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: register-map model with response queues checked
// every valid cycle, directed vectors with literal expectations, and a narrow instance for counter wrap.
module tb_axi_lite_reg_slave;
  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;

  logic [7:0]  sm_awaddr = '0, sm_araddr = '0, sm_wdata = '0;
  logic [1:0]  sm_wstrb = '0;
  logic        sm_awvalid = 1'b0, sm_wvalid = 1'b0, sm_arvalid = 1'b0;
  logic        sm_awready, sm_wready, sm_bvalid, sm_arready, sm_rvalid;
  logic [2:0]  sm_bresp, sm_rresp;
  logic [7:0]  sm_rdata;

  axi_lite_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(BASE)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  axi_lite_reg_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(0)) dut_narrow (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(sm_awaddr), .s_axi_awvalid(sm_awvalid), .s_axi_awready(sm_awready),
    .s_axi_wdata(sm_wdata), .s_axi_wstrb(sm_wstrb), .s_axi_wvalid(sm_wvalid), .s_axi_wready(sm_wready),
    .s_axi_bresp(sm_bresp), .s_axi_bvalid(sm_bvalid), .s_axi_bready(1'b1),
    .s_axi_araddr(sm_araddr), .s_axi_arvalid(sm_arvalid), .s_axi_arready(sm_arready),
    .s_axi_rdata(sm_rdata), .s_axi_rresp(sm_rresp), .s_axi_rvalid(sm_rvalid), .s_axi_rready(1'b1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_a = '0, m_b = '0, m_cnt = '0;
  logic [2:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  logic [2:0]  exp_rr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [2:0] m_resp(input logic [7:0] addr, input bit is_write);
    int off;
    off = (int'(addr) - BASE + 256) % 256;
    if (off >= 16 || (addr % 4) != 0) return 3'd3;
    if (is_write && off >= 8) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] addr);
    int off;
    off = (int'(addr) - BASE + 256) % 256;
    if (m_resp(addr, 1'b0) != 3'd0) return 32'd0;
    if (off == 0) return m_a;
    if (off == 4) return m_b;
    if (off == 8) return m_a + m_b;
    return m_cnt;
  endfunction

  task automatic m_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb);
    logic [31:0] mask;
    logic [2:0]  r;
    r = m_resp(addr, 1'b1);
    exp_b.push_back(r);
    if (r == 3'd0) begin
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      if (addr == 8'(BASE)) m_a = (m_a & ~mask) | (data & mask);
      else                  m_b = (m_b & ~mask) | (data & mask);
      m_cnt = m_cnt + 1;
    end
  endtask

  // Response channels compared against the model on every valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid) begin
        if (exp_b.size() == 0) fail("unexpected_bvalid");
        else begin
          check("mon_bresp", 32'(bresp), 32'(exp_b[0]));
          if (bready) void'(exp_b.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_rd.size() == 0) fail("unexpected_rvalid");
        else begin
          check("mon_rdata", rdata, exp_rd[0]);
          check("mon_rresp", 32'(rresp), 32'(exp_rr[0]));
          if (rready) begin
            void'(exp_rd.pop_front());
            void'(exp_rr.pop_front());
          end
        end
      end
      if (awready) check("awready_with_bvalid", 32'(bvalid), 32'd0);
    end
  end

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                    input int awd, input int wd, output logic [2:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
    m_write(addr, data, strb);
    awaddr = addr; wdata = data; wstrb = strb;
    for (int c = 0; c < 64 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      if (!aw_done && c >= awd) awvalid = 1'b1;
      if (!w_done && c >= wd) wvalid = 1'b1;
      if (aw_done && !w_done) begin
        check("aw_held_awready", 32'(awready), 32'd0);
        check("aw_held_bvalid", 32'(bvalid), 32'd0);
      end
      if (w_done && !aw_done) begin
        check("w_held_wready", 32'(wready), 32'd0);
        check("w_held_bvalid", 32'(bvalid), 32'd0);
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    resp = 3'd7;
    if (!(aw_done && w_done)) fail("wr_handshake");
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; end
    end
    if (!got) fail("wr_bvalid");
    else if (bready) @(posedge clk);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
    bit hs = 0, got = 0;
    exp_rd.push_back(m_read(addr));
    exp_rr.push_back(m_resp(addr, 1'b0));
    araddr = addr;
    for (int c = 0; c < 64 && !hs; c++) begin
      @(negedge clk); arvalid = 1'b1; hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    data = 32'hxxxx_xxxx; resp = 3'd7;
    if (!hs) fail("rd_handshake");
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      if (rvalid) begin got = 1; data = rdata; resp = rresp; end
    end
    if (!got) fail("rd_rvalid");
    else if (rready) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_b.delete(); exp_rd.delete(); exp_rr.delete();
    m_a = '0; m_b = '0; m_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sm_writes(input int n);
    int seen = 0;
    sm_awaddr = 8'd0; sm_wdata = 8'h01; sm_wstrb = 2'b11;
    @(negedge clk);
    check("sm_ready", {30'd0, sm_awready, sm_wready}, 32'd3);
    sm_awvalid = 1'b1; sm_wvalid = 1'b1;
    for (int c = 0; c < 8 * n + 20 && seen < n; c++) begin
      @(negedge clk);
      if (sm_bvalid) begin
        seen++;
        if (sm_bresp != 3'd0) check("sm_bresp", 32'(sm_bresp), 32'd0);
        if (seen == n) begin sm_awvalid = 1'b0; sm_wvalid = 1'b0; end
      end
    end
    sm_awvalid = 1'b0; sm_wvalid = 1'b0;
    if (seen != n) fail("sm_writes");
  endtask

  task automatic sm_rd(input logic [7:0] addr, output logic [7:0] data);
    bit hs = 0, got = 0;
    sm_araddr = addr; data = 8'hxx;
    for (int c = 0; c < 32 && !hs; c++) begin
      @(negedge clk); sm_arvalid = 1'b1; hs = sm_arready;
      @(posedge clk); #1;
    end
    sm_arvalid = 1'b0;
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      if (sm_rvalid) begin got = 1; data = sm_rdata; check("sm_rresp", 32'(sm_rresp), 32'd0); end
    end
    if (!got) fail("sm_rd");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r;
    logic [31:0] d;
    logic [7:0]  sd;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {21'd0, awready, wready, arready, bvalid, rvalid, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    check("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {29'd0, awready, wready, arready}, 32'd7);

    wr(8'(BASE + 0), 32'h0000_0005, 5'h0F, 0, 0, r); check("wr_a_resp", 32'(r), 32'd0);
    wr(8'(BASE + 4), 32'h0000_000A, 5'h0F, 0, 0, r); check("wr_b_resp", 32'(r), 32'd0);
    rd(8'(BASE + 8), d, r);  check("sum_data", d, 32'h0000_000F); check("sum_resp", 32'(r), 32'd0);
    rd(8'(BASE + 12), d, r); check("wcount_2", d, 32'd2);

    wr(8'(BASE + 0), 32'h1111_2222, 5'h0F, 0, 3, r); check("aw_first_resp", 32'(r), 32'd0);
    rd(8'(BASE + 0), d, r);  check("aw_first_a", d, 32'h1111_2222);
    wr(8'(BASE + 0), 32'h3333_4444, 5'h0F, 3, 0, r); check("w_first_resp", 32'(r), 32'd0);
    rd(8'(BASE + 0), d, r);  check("w_first_a", d, 32'h3333_4444);

    wr(8'(BASE + 0), 32'hFFFF_FFFF, 5'h0F, 0, 0, r);
    wr(8'(BASE + 0), 32'h1234_5678, 5'h15, 0, 0, r);
    rd(8'(BASE + 0), d, r);  check("strobe_a", d, 32'hFF34_FF78);

    wr(8'(BASE + 8), 32'h0000_0001, 5'h0F, 0, 0, r); check("wr_sum_slverr", 32'(r), 32'd2);
    rd(8'(BASE + 8), d, r);  check("sum_after_slverr", d, 32'hFF34_FF82);
    rd(8'(BASE + 12), d, r); check("wcount_6", d, 32'd6);
    wr(8'(BASE + 12), 32'h0, 5'h0F, 0, 0, r);        check("wr_cnt_slverr", 32'(r), 32'd2);
    rd(8'(BASE + 16), d, r); check("rd_oob_resp", 32'(r), 32'd3); check("rd_oob_data", d, 32'd0);
    wr(8'(BASE + 2), 32'hAAAA_AAAA, 5'h0F, 0, 0, r); check("wr_misalign", 32'(r), 32'd3);
    rd(8'(BASE - 4), d, r);  check("rd_below_base", 32'(r), 32'd3);
    wr(8'(BASE + 0), 32'h0, 5'h00, 0, 0, r);         check("wstrb0_resp", 32'(r), 32'd0);
    rd(8'(BASE + 0), d, r);  check("wstrb0_a", d, 32'hFF34_FF78);
    rd(8'(BASE + 12), d, r); check("wcount_7", d, 32'd7);

    @(posedge clk); #1; bready = 1'b0;
    wr(8'(BASE + 4), 32'h0000_0077, 5'h0F, 0, 0, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bresp", 32'(bresp), 32'(r));
      check("bp_ready", {30'd0, awready, wready}, 32'd0);
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    rd(8'(BASE + 4), d, r);  check("bp_rd_b", d, 32'h0000_0077);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rdata", rdata, 32'h0000_0077);
      check("bp_arready", {30'd0, arready, rvalid}, 32'd1);
    end
    @(posedge clk); #1; rready = 1'b1;
    @(posedge clk);

    @(negedge clk); awaddr = 8'(BASE); awvalid = 1'b1;
    check("mw_awready", 32'(awready), 32'd1);
    @(posedge clk); #1; awvalid = 1'b0;
    do_reset();
    @(negedge clk); wdata = 32'hDEAD_BEEF; wstrb = 5'h0F; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("mw_no_bvalid", 32'(bvalid), 32'd0);
    end
    rd(8'(BASE + 0), d, r);  check("mw_a", d, 32'd0);
    rd(8'(BASE + 12), d, r); check("mw_wcount", d, 32'd0);
    do_reset();

    wr(8'(BASE + 0), 32'hFFFF_FFFF, 5'h0F, 0, 0, r);
    wr(8'(BASE + 4), 32'h0000_0001, 5'h0F, 0, 0, r);
    rd(8'(BASE + 8), d, r);  check("sum_wrap", d, 32'd0);
    rd(8'(BASE + 12), d, r); check("wcount_after_reset", d, 32'd2);

    sm_writes(255);
    sm_rd(8'd12, sd); check("narrow_wcount_ff", 32'(sd), 32'h0000_00FF);
    sm_writes(1);
    sm_rd(8'd12, sd); check("narrow_wcount_wrap", 32'(sd), 32'd0);
    sm_rd(8'd0, sd);  check("narrow_a", 32'(sd), 32'h0000_0001);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
